ls_mem_arbiter: RTL

- Two-requester arbiter and sequencer for the 8x8 load/store data memory (read/write-enable, select-enable, 3-bit address, 8-bit write/read data).
- Requester 0 is the load/store execution unit; requester 1 is the host/debug port.
- Owns all memory strobes and serialises accesses one at a time with round-robin fairness.
- Returns read data and a one-cycle completion pulse to the winning requester.

---
 rtl/ls_mem_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ls_mem_arbiter.sv
// ls_mem_arbiter: two-requester round-robin arbiter and sequencer for the
// 8x8 load/store data memory. Requester 0 is the load/store unit and
// requester 1 is the host/debug port. Accesses are serialised one at a
// time as IDLE -> ACCESS -> DONE. Every output comes straight from a flop.
module ls_mem_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // last_grant_reg remembers the most recent winner so a tie goes to the other side.
  logic last_grant_reg, last_grant_next;
  logic sel_reg, sel_next;
  logic win;

  logic              busy_reg, busy_next;
  logic              mem_en_reg, mem_en_next;
  logic              mem_rd_en_reg, mem_rd_en_next;
  logic              mem_wr_en_reg, mem_wr_en_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [1:0]        done_reg, done_next;

  // Requester inputs gathered into arrays so the winner can be picked by index.
  logic [1:0]        req_vec;
  logic [1:0]        we_vec;
  logic [ADDR_W-1:0] addr_vec  [2];
  logic [DATA_W-1:0] wdata_vec [2];

  assign req_vec      = {req1, req0};
  assign we_vec       = {we1, we0};
  assign addr_vec[0]  = addr0;
  assign addr_vec[1]  = addr1;
  assign wdata_vec[0] = wdata0;
  assign wdata_vec[1] = wdata1;

  // The served requester gets its done pulse in the cycle after ACCESS.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_done
      assign done_next[gi] = (state_reg == ACCESS) && (int'(sel_reg) == gi);
    end
  endgenerate

  // Next-state, grant selection and next output values.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    sel_next        = sel_reg;
    win             = 1'b0;
    busy_next       = 1'b0;
    mem_en_next     = 1'b0;
    mem_rd_en_next  = 1'b0;
    mem_wr_en_next  = 1'b0;
    mem_addr_next   = '0;
    mem_wdata_next  = '0;
    rdata_next      = rdata_reg;

    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          // A tie goes to whoever did not win last; otherwise the lone requester.
          if (req_vec == 2'b11) begin
            win = ~last_grant_reg;
          end else begin
            win = req_vec[1];
          end
          sel_next        = win;
          last_grant_next = win;
          busy_next       = 1'b1;
          mem_en_next     = 1'b1;
          mem_wr_en_next  = we_vec[win];
          mem_rd_en_next  = ~we_vec[win];
          mem_addr_next   = addr_vec[win];
          mem_wdata_next  = wdata_vec[win];
          state_next      = ACCESS;
        end
      end
      ACCESS: begin
        // Strobes fall at this edge; a load samples the memory as they do.
        busy_next  = 1'b1;
        state_next = DONE;
        if (mem_rd_en_reg) begin
          rdata_next = mem_rdata;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and arbitration registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      sel_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      sel_reg        <= sel_next;
    end
  end

  // Output registers; reset drops every strobe and pulse at once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      busy_reg      <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_rd_en_reg <= 1'b0;
      mem_wr_en_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rdata_reg     <= '0;
      done_reg      <= 2'b00;
    end else begin
      busy_reg      <= busy_next;
      mem_en_reg    <= mem_en_next;
      mem_rd_en_reg <= mem_rd_en_next;
      mem_wr_en_reg <= mem_wr_en_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rdata_reg     <= rdata_next;
      done_reg      <= done_next;
    end
  end

  assign busy      = busy_reg;
  assign mem_en    = mem_en_reg;
  assign mem_rd_en = mem_rd_en_reg;
  assign mem_wr_en = mem_wr_en_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rdata     = rdata_reg;
  assign done0     = done_reg[0];
  assign done1     = done_reg[1];

endmodule
